// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack word-crossing blocks.
package cdc_pkg;

  localparam int SYNC_STAGES_DEF = 5;
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_REL   = 2'd3
  } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single level signal entering this clock domain.
module sync_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  // Fewer than two flops cannot resolve metastability, so clamp upward.
  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  (* ASYNC_REG = "TRUE" *) logic [N-2:0] meta_q;
  logic                                 out_q;

  // Shift the asynchronous level through the chain; the last flop is the clean copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      out_q  <= 1'b0;
    end else begin
      for (int i = N - 2; i > 0; i--) meta_q[i] <= meta_q[i-1];
      meta_q[0] <= d_i;
      out_q     <= meta_q[N-2];
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/cdc_word_tx.sv
// Source half of a four-phase req/ack crossing: captures a word, holds it on
// data_out, raises req_out and waits for the synchronized ack to rise and fall.
module cdc_word_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = 0
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic                  done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int SS    = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SS-1:0]           warm_q;
  logic                    ack_s;
  logic                    accept;
  logic                    waiting;

  sync_chain #(.STAGES(SS)) u_ack_sync (
    .clk_i (clk_in),
    .rst_i (rst),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  // The sync chain is cleared by reset, so ack_s is meaningless until the chain
  // has refilled from ack_in. warm_q[SS-1] marks that point; without it a far
  // side still holding ack after a reset would look idle and a new request
  // could overlap the stale ack.
  assign s_ready = !rst && warm_q[SS-1] && (state_q == ST_IDLE) && !ack_s;
  assign busy    = (state_q != ST_IDLE);
  assign accept  = s_valid && s_ready;

  // Handshake sequencing and word capture.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = s_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_REQ;
      ST_REQ:   if (ack_s) state_d = ST_REL;
      ST_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  // Wait-time watchdog: restarts on every state change, saturates, flags once.
  always_comb begin
    waiting = (state_q == ST_REQ) || (state_q == ST_REL);
    cnt_d   = '0;
    err_d   = err_q;
    if ((TIMEOUT > 0) && waiting && (state_d == state_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) err_d = 1'b1;
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      warm_q  <= {warm_q[SS-2:0], 1'b1};
    end
  end

  assign data_out    = data_q;
  assign req_out     = req_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_word_tx.sv
// Bench for cdc_word_tx: transaction-level model plus directed literal checks.
module tb_cdc_word_tx;

  localparam int DW = 32;
  localparam int SS = 5;
  localparam int TO = 20;
  localparam logic [1:0] M_LOOP = 2'd0, M_FORCE = 2'd1, M_FAR = 2'd2;

  logic          clk_in, far_clk;
  logic          rst, s_valid, s_ready, req_out, ack_in, done, busy, timeout_err;
  logic [DW-1:0] s_data, data_out;
  logic [1:0]    mode;
  logic          ack_force, far_ack;

  int checks = 0, errors = 0;
  int cyc = 0;

  // model state
  bit            model_on = 0;
  int            ph = 0;          // 0 idle, 1 setup, 2 req, 3 rel
  int            waitc = 0;
  bit            req_m = 0, done_m = 0, err_m = 0;
  logic [DW-1:0] dout_m = '0;
  bit            hist[$];         // ack_in samples since reset, oldest first

  int            done_t[$];
  logic [DW-1:0] sent_q[$], far_sampled[$];
  bit            fr1 = 0, fr2 = 0;

  cdc_word_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .data_out(data_out), .req_out(req_out), .ack_in(ack_in),
    .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  assign ack_in = (mode == M_LOOP) ? req_out : ((mode == M_FORCE) ? ack_force : far_ack);

  // time unit 0.05 ns: 10 ns source clock, 7.3 ns far clock with odd-time posedges
  initial begin clk_in = 0; forever #100 clk_in = ~clk_in; end
  initial begin far_clk = 0; forever #73 far_clk = ~far_clk; end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    return !rst && ph == 0 && hist.size() == SS && hist[0] == 1'b0;
  endfunction

  task automatic tick();
    if (waitc < TO) waitc++;
    if (waitc == TO) err_m = 1;
  endtask

  // Model: ack_s is ack_in delayed SS edges, unknown (low) until SS samples since reset.
  task automatic model_step();
    bit acks, rdy;
    if (rst) begin
      ph = 0; req_m = 0; done_m = 0; err_m = 0; dout_m = '0; waitc = 0;
      hist.delete(); model_on = 1;
    end else begin
      acks   = (hist.size() == SS) ? hist[0] : 1'b0;
      rdy    = (ph == 0) && (hist.size() == SS) && !acks;
      done_m = 0;
      case (ph)
        0: if (s_valid && rdy) begin dout_m = s_data; ph = 1; end
        1: begin ph = 2; waitc = 0; end
        2: if (acks) begin ph = 3; waitc = 0; end else tick();
        3: if (!acks) begin ph = 0; done_m = 1; end else tick();
        default: ph = 0;
      endcase
      hist.push_back(ack_in);
      if (hist.size() > SS) void'(hist.pop_front());
      req_m = (ph == 2);
    end
  endtask

  initial forever begin @(posedge clk_in); cyc++; model_step(); end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk_in);
    if (model_on) begin
      chk("s_ready", s_ready, m_ready());
      chk("busy", busy, ph != 0);
      chk("req_out", req_out, req_m);
      chk("done", done, done_m);
      chk("data_out", data_out, dout_m);
      chk("timeout_err", timeout_err, err_m);
      if (done === 1'b1) done_t.push_back(cyc);
    end
  end

  // Far-domain responder: two-flop sync of req_out, random 0-10 cycle delay.
  initial begin
    int d;
    far_ack = 0;
    forever begin
      @(posedge far_clk);
      fr2 = fr1; fr1 = req_out;
      if (mode == M_FAR) begin
        if (fr2 && !far_ack) begin
          far_sampled.push_back(data_out);
          d = $urandom_range(0, 10);
          repeat (d) @(posedge far_clk);
          far_ack = 1;
        end else if (!fr2 && far_ack) begin
          d = $urandom_range(0, 10);
          repeat (d) @(posedge far_clk);
          far_ack = 0;
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1;
    repeat (2) @(negedge clk_in);
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", s_ready, 0);
    rst = 0;
    repeat (SS + 1) @(negedge clk_in);
  endtask

  // Present a word and return at the negedge after the accepting edge; valid stays high.
  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    s_data = w; s_valid = 1;
    while (s_ready !== 1'b1 && n < 200) begin @(negedge clk_in); n++; end
    chk("accept_wait", n < 200, 1);
    @(negedge clk_in);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk_in); n++; end
    chk("idle_wait", n < 200, 1);
  endtask

  initial begin
    logic [DW-1:0] w;
    int n;
    mode = M_FORCE; ack_force = 0; rst = 1; s_valid = 0; s_data = '0;
    reset_dut();

    // Loopback timing: accept at edge 0, req 1..6, done in cycle 13, next at 14
    mode = M_LOOP;
    chk("lb_ready0", s_ready, 1);
    send(32'hDEADBEEF);
    s_valid = 0;
    for (int k = 0; k <= 14; k++) begin
      chk("lb_req", req_out, (k >= 1 && k <= 6));
      chk("lb_done", done, (k == 13));
      chk("lb_ready", s_ready, (k == 13));
      chk("lb_data", data_out, (k < 14) ? 32'hDEADBEEF : 32'h12345678);
      if (k == 13) begin s_valid = 1; s_data = 32'h12345678; end
      if (k == 14) s_valid = 0;
      @(negedge clk_in);
    end
    wait_idle();

    // Back-to-back stream, valid held high
    done_t.delete();
    send(32'd1); send(32'd2); send(32'd3);
    s_valid = 0;
    wait_idle();
    @(negedge clk_in);
    chk("b2b_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      chk("b2b_gap1", done_t[1] - done_t[0], 14);
      chk("b2b_gap2", done_t[2] - done_t[1], 14);
    end

    // Data stability while s_data churns
    send(32'hA5A50F0F);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("stab_data", data_out, 32'hA5A50F0F);
      chk("stab_ready", s_ready, 0);
      s_data = $urandom; s_valid = 1'($urandom_range(0, 1));
      @(negedge clk_in); n++;
    end
    s_valid = 0;
    chk("stab_final", data_out, 32'hA5A50F0F);
    @(negedge clk_in);

    // Timeout with ack tied low: req at edge 1, error after edge 21
    mode = M_FORCE; ack_force = 0;
    send(32'h0BADF00D);
    s_valid = 0;
    for (int k = 0; k <= 22; k++) begin
      chk("to_req", req_out, (k >= 1));
      chk("to_err", timeout_err, (k >= 21));
      @(negedge clk_in);
    end
    ack_force = 1;
    n = 0;
    while (req_out !== 1'b0 && n < 30) begin @(negedge clk_in); n++; end
    chk("to_ackwait", n < 30, 1);
    ack_force = 0;
    wait_idle();
    chk("to_sticky", timeout_err, 1);

    // Reset mid-REQ with ack held high
    reset_dut();
    done_t.delete();
    send(32'h0C0FFEE0);
    s_valid = 0;
    @(negedge clk_in);
    chk("mr_req", req_out, 1);
    ack_force = 1;
    @(negedge clk_in);
    rst = 1;
    @(negedge clk_in);
    chk("mr_req_rst", req_out, 0);
    chk("mr_busy_rst", busy, 0);
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("mr_hold", s_ready, 0);
    end
    ack_force = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk_in);
      chk("mr_release", s_ready, (j == 4));
    end
    chk("mr_nodone", done_t.size(), 0);

    // Asynchronous far side, 1000 words
    reset_dut();
    mode = M_FAR;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      sent_q.push_back(w);
      send(w);
    end
    s_valid = 0;
    wait_idle();
    repeat (3) @(negedge clk_in);
    chk("far_count", far_sampled.size(), 1000);
    for (int i = 0; i < 1000 && i < far_sampled.size(); i++)
      chk("far_word", far_sampled[i], sent_q[i]);
    chk("far_noerr", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
